// File: rtl/cisc_cpu_p.sv
// Multi-cycle x86-subset CPU (FETCH/DECODE/MEM/HALT) with separate instruction and data buses.
// Instructions execute in DECODE; only ModRM mod=01 loads/stores visit MEM.
module cisc_cpu_p (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] bus_A_ins,
   input  logic [31:0] bus_in_ins,
   output logic        bus_RE_ins,
   output logic [31:0] bus_A_data,
   input  logic [31:0] bus_in_data,
   output logic        bus_RE_data,
   output logic        bus_WE,
   output logic [31:0] bus_out,
   output logic [7:0]  current_opcode
);

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      DECODE = 2'd1,
      MEM    = 2'd2,
      HALT   = 2'd3
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] pc;
   logic [31:0] pc_next;
   logic [31:0] ir;
   logic [31:0] regs [8];
   logic        zf;
   logic        sf;
   logic        cf;
   logic [31:0] wb_q;
   logic [31:0] st_q;

   logic [7:0]  op;
   logic [7:0]  modrm;
   logic [7:0]  disp8;
   logic [1:0]  mod;
   logic [2:0]  rg;
   logic [2:0]  rm;
   logic [31:0] src_val;
   logic [31:0] dst_val;
   logic [31:0] ea;
   logic [31:0] pc_plus1;
   logic [31:0] pc_plus2;
   logic [31:0] pc_plus3;
   logic [31:0] br_target;
   logic [32:0] add_sum;
   logic [32:0] sub_dif;

   logic        wr_en;
   logic [2:0]  wr_idx;
   logic [31:0] wr_data;
   logic        flag_en;
   logic        cf_new;
   logic        mem_start;
   logic        mem_cycle;
   logic        unused_bits;

   assign op        = bus_in_ins[7:0];
   assign modrm     = bus_in_ins[15:8];
   assign disp8     = bus_in_ins[23:16];
   assign mod       = modrm[7:6];
   assign rg        = modrm[5:3];
   assign rm        = modrm[2:0];
   assign src_val   = regs[rg];
   assign dst_val   = regs[rm];
   assign ea        = dst_val + {{24{disp8[7]}}, disp8};
   assign pc_plus1  = pc + 32'd1;
   assign pc_plus2  = pc + 32'd2;
   assign pc_plus3  = pc + 32'd3;
   assign br_target = pc_plus2 + {{24{modrm[7]}}, modrm};
   // Bit 32 of the subtraction is the borrow out.
   assign add_sum   = {1'b0, dst_val} + {1'b0, src_val};
   assign sub_dif   = {1'b0, dst_val} - {1'b0, src_val};

   always_comb begin
      state_next = state;
      pc_next    = pc;
      wr_en      = 1'b0;
      wr_idx     = rm;
      wr_data    = 32'd0;
      flag_en    = 1'b0;
      cf_new     = 1'b0;
      mem_start  = 1'b0;
      case (state)
         FETCH: state_next = DECODE;
         DECODE: begin
            state_next = FETCH;
            pc_next    = pc_plus1;
            case (op)
               8'h01: if (mod == 2'b11) begin
                  pc_next = pc_plus2;
                  wr_en   = 1'b1;
                  wr_data = add_sum[31:0];
                  flag_en = 1'b1;
                  cf_new  = add_sum[32];
               end
               8'h29: if (mod == 2'b11) begin
                  pc_next = pc_plus2;
                  wr_en   = 1'b1;
                  wr_data = sub_dif[31:0];
                  flag_en = 1'b1;
                  cf_new  = sub_dif[32];
               end
               8'h89: begin
                  if (mod == 2'b11) begin
                     pc_next = pc_plus2;
                     wr_en   = 1'b1;
                     wr_idx  = rm;
                     wr_data = src_val;
                  end else if (mod == 2'b01) begin
                     pc_next    = pc_plus3;
                     mem_start  = 1'b1;
                     state_next = MEM;
                  end
               end
               8'h8B: begin
                  if (mod == 2'b11) begin
                     pc_next = pc_plus2;
                     wr_en   = 1'b1;
                     wr_idx  = rg;
                     wr_data = dst_val;
                  end else if (mod == 2'b01) begin
                     pc_next    = pc_plus3;
                     mem_start  = 1'b1;
                     state_next = MEM;
                  end
               end
               8'h74:   pc_next = zf ? br_target : pc_plus2;
               8'h75:   pc_next = zf ? pc_plus2 : br_target;
               8'hEB:   pc_next = br_target;
               8'hF4:   state_next = HALT;
               default: pc_next = pc_plus1;
            endcase
         end
         MEM: begin
            state_next = FETCH;
            // ir[1] separates 0x8B (load) from 0x89 (store).
            if (ir[1]) begin
               wr_en   = 1'b1;
               wr_idx  = ir[13:11];
               wr_data = bus_in_data;
            end
         end
         HALT:    state_next = HALT;
         default: state_next = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= FETCH;
         pc         <= 32'd0;
         ir         <= 32'd0;
         zf         <= 1'b0;
         sf         <= 1'b0;
         cf         <= 1'b0;
         wb_q       <= 32'd0;
         st_q       <= 32'd0;
         bus_A_data <= 32'd0;
         for (int i = 0; i < 8; i++) regs[i] <= 32'd0;
      end else begin
         state <= state_next;
         pc    <= pc_next;
         if (state == DECODE) ir <= bus_in_ins;
         if (wr_en) begin
            regs[wr_idx] <= wr_data;
            wb_q         <= wr_data;
         end
         if (flag_en) begin
            zf <= (wr_data == 32'd0);
            sf <= wr_data[31];
            cf <= cf_new;
         end
         if (mem_start) begin
            bus_A_data <= ea;
            st_q       <= src_val;
         end
      end
   end

   // Enables are gated by rst so a reset arriving mid-access drops them at once.
   assign mem_cycle      = (state == MEM) && !rst;
   assign bus_A_ins      = pc;
   assign bus_RE_ins     = (state == FETCH) && !rst;
   assign bus_RE_data    = mem_cycle && ir[1];
   assign bus_WE         = mem_cycle && !ir[1];
   assign bus_out        = bus_WE ? st_q : wb_q;
   assign current_opcode = ir[7:0];

   assign unused_bits = ^{ir[31:14], ir[10:8], bus_in_ins[31:24]};

endmodule

// File: tb/tb_cisc_cpu_p.sv
// Bench for cisc_cpu_p: directed programs plus random straight-line/forward-branch programs
// checked against an instruction-level interpreter.
module tb_cisc_cpu_p;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] bus_A_ins;
   logic [31:0] bus_in_ins = 32'd0;
   logic        bus_RE_ins;
   logic [31:0] bus_A_data;
   logic [31:0] bus_in_data = 32'd0;
   logic        bus_RE_data;
   logic        bus_WE;
   logic [31:0] bus_out;
   logic [7:0]  current_opcode;

   always #5 clk = ~clk;

   cisc_cpu_p dut (
      .clk(clk), .rst(rst),
      .bus_A_ins(bus_A_ins), .bus_in_ins(bus_in_ins), .bus_RE_ins(bus_RE_ins),
      .bus_A_data(bus_A_data), .bus_in_data(bus_in_data), .bus_RE_data(bus_RE_data),
      .bus_WE(bus_WE), .bus_out(bus_out), .current_opcode(current_opcode)
   );

   logic [7:0]  imem [256];
   logic [7:0]  dmem [256];
   logic [7:0]  prog_q [$];
   logic [63:0] exp_q [$];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          fetch_cnt = 0;
   int          last_fetch = 0;
   int          we_cnt = 0;
   bit          running = 1'b0;

   // reference model results
   logic [31:0] m_r [8];
   logic        m_z, m_s, m_c;
   logic [31:0] m_pc, m_bus;
   logic [7:0]  m_op;
   int          m_nf, m_last;
   logic [7:0]  m_dmem [256];

   function automatic logic [31:0] iword(input logic [31:0] a);
      logic [7:0] b;
      b = a[7:0];
      return {imem[b + 8'd3], imem[b + 8'd2], imem[b + 8'd1], imem[b]};
   endfunction

   function automatic logic [31:0] dword(input logic [31:0] a);
      logic [7:0] b;
      b = a[7:0];
      return {dmem[b + 8'd3], dmem[b + 8'd2], dmem[b + 8'd1], dmem[b]};
   endfunction

   function automatic logic [31:0] sx8(input logic [7:0] b);
      return {{24{b[7]}}, b};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // memories: instruction word one cycle after the address, data sampled at negedge
   always @(posedge clk) begin
      if (bus_RE_ins) bus_in_ins <= iword(bus_A_ins);
      if (bus_WE) begin
         dmem[bus_A_data[7:0]]         = bus_out[7:0];
         dmem[bus_A_data[7:0] + 8'd1]  = bus_out[15:8];
         dmem[bus_A_data[7:0] + 8'd2]  = bus_out[23:16];
         dmem[bus_A_data[7:0] + 8'd3]  = bus_out[31:24];
      end
   end

   always @(negedge clk) begin
      if (bus_RE_data) bus_in_data <= dword(bus_A_data);
   end

   // scoreboard monitor: fetch timing and store stream
   always @(negedge clk) begin
      logic [63:0] e;
      if (running) begin
         if (bus_RE_ins) begin
            fetch_cnt++;
            last_fetch = cyc;
         end
         if (bus_WE) begin
            we_cnt++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hFFFF_FFFF_FFFF_FFFF;
            check("store_addr", bus_A_data, e[63:32]);
            check("store_data", bus_out, e[31:0]);
         end
         cyc++;
      end
   end

   task automatic model_run();
      logic [7:0]  op, b1, b2;
      logic [31:0] a, b, ea, res, val;
      logic [32:0] wide;
      bit          done, taken;
      int          c;
      for (int i = 0; i < 8; i++) m_r[i] = 32'd0;
      for (int i = 0; i < 256; i++) m_dmem[i] = dmem[i];
      m_z = 0; m_s = 0; m_c = 0; m_pc = 0; m_bus = 0; m_nf = 0; m_last = 0; m_op = 0;
      c = 0; done = 0;
      exp_q.delete();
      for (int step = 0; step < 1000 && !done; step++) begin
         op = imem[m_pc[7:0]];
         b1 = imem[m_pc[7:0] + 8'd1];
         b2 = imem[m_pc[7:0] + 8'd2];
         m_nf++; m_last = c; m_op = op;
         if ((op == 8'h01 || op == 8'h29) && b1[7:6] == 2'b11) begin
            a = m_r[b1[2:0]]; b = m_r[b1[5:3]];
            if (op == 8'h01) begin
               wide = 33'(a) + 33'(b); res = wide[31:0]; m_c = wide[32];
            end else begin
               res = a - b; m_c = (a < b);
            end
            m_z = (res == 0); m_s = res[31]; m_r[b1[2:0]] = res; m_bus = res;
            m_pc += 2; c += 2;
         end else if ((op == 8'h89 || op == 8'h8B) && b1[7:6] == 2'b11) begin
            if (op == 8'h89) begin m_r[b1[2:0]] = m_r[b1[5:3]]; m_bus = m_r[b1[2:0]]; end
            else begin m_r[b1[5:3]] = m_r[b1[2:0]]; m_bus = m_r[b1[5:3]]; end
            m_pc += 2; c += 2;
         end else if ((op == 8'h89 || op == 8'h8B) && b1[7:6] == 2'b01) begin
            ea = m_r[b1[2:0]] + sx8(b2);
            if (op == 8'h89) begin
               val = m_r[b1[5:3]];
               exp_q.push_back({ea, val});
               for (int k = 0; k < 4; k++) m_dmem[ea[7:0] + 8'(k)] = val[8*k +: 8];
            end else begin
               for (int k = 0; k < 4; k++) val[8*k +: 8] = m_dmem[ea[7:0] + 8'(k)];
               m_r[b1[5:3]] = val; m_bus = val;
            end
            m_pc += 3; c += 3;
         end else if (op == 8'h74 || op == 8'h75 || op == 8'hEB) begin
            taken = (op == 8'hEB) || (op == 8'h74 && m_z) || (op == 8'h75 && !m_z);
            m_pc = m_pc + 2 + (taken ? sx8(b1) : 32'd0); c += 2;
         end else if (op == 8'hF4) begin
            m_pc += 1; done = 1;
         end else begin
            m_pc += 1; c += 2;
         end
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) begin imem[i] = 8'hF4; dmem[i] = 8'h00; end
   endtask

   task automatic load_prog();
      for (int i = 0; i < prog_q.size(); i++) imem[i] = prog_q[i];
   endtask

   task automatic dset(input logic [7:0] a, input logic [31:0] v);
      for (int k = 0; k < 4; k++) dmem[a + 8'(k)] = v[8*k +: 8];
   endtask

   function automatic logic [7:0] safe(input logic [7:0] b);
      return (b == 8'h74 || b == 8'h75 || b == 8'hEB) ? (b ^ 8'h02) : b;
   endfunction

   task automatic gen_prog();
      int p, n;
      logic [7:0] undef_ops [4];
      logic [7:0] odd_ops [4];
      logic [7:0] br_ops [3];
      undef_ops = '{8'hB8, 8'h00, 8'h0F, 8'hC3};
      odd_ops   = '{8'h01, 8'h29, 8'h89, 8'h8B};
      br_ops    = '{8'h74, 8'h75, 8'hEB};
      for (int i = 0; i < 256; i++) begin imem[i] = 8'hF4; dmem[i] = 8'($urandom); end
      p = 0;
      n = $urandom_range(6, 24);
      for (int k = 0; k < n; k++) begin
         case ($urandom_range(0, 9))
            0, 1: begin
               imem[p] = ($urandom_range(0, 1) != 0) ? 8'h01 : 8'h29;
               imem[p+1] = safe({2'b11, 6'($urandom)}); p += 2;
            end
            2: begin
               imem[p] = ($urandom_range(0, 1) != 0) ? 8'h89 : 8'h8B;
               imem[p+1] = safe({2'b11, 6'($urandom)}); p += 2;
            end
            3, 4, 5: begin
               imem[p] = ($urandom_range(0, 2) != 0) ? 8'h8B : 8'h89;
               imem[p+1] = safe({2'b01, 6'($urandom)});
               imem[p+2] = safe(8'($urandom)); p += 3;
            end
            6: begin
               imem[p] = br_ops[$urandom_range(0, 2)];
               imem[p+1] = 8'($urandom_range(0, 6)); p += 2;
            end
            7: begin imem[p] = 8'h90; p += 1; end
            8: begin imem[p] = undef_ops[$urandom_range(0, 3)]; p += 1; end
            default: begin
               imem[p] = odd_ops[$urandom_range(0, 3)];
               imem[p+1] = {($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00, 6'($urandom)}; p += 2;
            end
         endcase
      end
   endtask

   task automatic run_check(input string tag);
      int idle, guard, diffs;
      running = 0;
      model_run();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_rst_A_ins"}, bus_A_ins, 32'd0);
      check({tag, "_rst_RE_ins"}, 32'(bus_RE_ins), 32'd0);
      check({tag, "_rst_A_data"}, bus_A_data, 32'd0);
      check({tag, "_rst_RE_data"}, 32'(bus_RE_data), 32'd0);
      check({tag, "_rst_WE"}, 32'(bus_WE), 32'd0);
      check({tag, "_rst_out"}, bus_out, 32'd0);
      check({tag, "_rst_opcode"}, 32'(current_opcode), 32'd0);
      rst = 1'b0;
      cyc = 0; fetch_cnt = 0; last_fetch = 0; we_cnt = 0;
      running = 1'b1;
      @(negedge clk);
      check({tag, "_first_addr"}, bus_A_ins, 32'd0);
      check({tag, "_first_re"}, 32'(bus_RE_ins), 32'd1);
      idle = 0; guard = 0;
      while (idle < 6 && guard < 3000) begin
         @(negedge clk);
         idle = (bus_RE_ins || bus_RE_data || bus_WE) ? 0 : idle + 1;
         guard++;
      end
      running = 1'b0;
      check({tag, "_halted"}, 32'(idle), 32'd6);
      for (int i = 0; i < 8; i++) check($sformatf("%s_r%0d", tag, i), dut.regs[i], m_r[i]);
      check({tag, "_zf"}, 32'(dut.zf), 32'(m_z));
      check({tag, "_sf"}, 32'(dut.sf), 32'(m_s));
      check({tag, "_cf"}, 32'(dut.cf), 32'(m_c));
      check({tag, "_pc"}, bus_A_ins, m_pc);
      check({tag, "_opcode"}, 32'(current_opcode), 32'(m_op));
      check({tag, "_bus_out"}, bus_out, m_bus);
      check({tag, "_fetches"}, 32'(fetch_cnt), 32'(m_nf));
      check({tag, "_hlt_cycle"}, 32'(last_fetch), 32'(m_last));
      check({tag, "_stores_left"}, 32'(exp_q.size()), 32'd0);
      diffs = 0;
      for (int i = 0; i < 256; i++) if (dmem[i] !== m_dmem[i]) diffs++;
      check({tag, "_dmem"}, 32'(diffs), 32'd0);
   endtask

   initial begin
      int guard;

      // counting loop: eax=1..10, ebx accumulates the sum
      clear_mem();
      prog_q = '{8'h29, 8'hF6, 8'h29, 8'hC0, 8'h29, 8'hDB, 8'h8B, 8'h56, 8'h17, 8'h01, 8'hD0,
                 8'h01, 8'hC3, 8'h89, 8'hC1, 8'h8B, 8'h56, 8'h1B, 8'h29, 8'hD1, 8'h75, 8'hF0, 8'hF4};
      load_prog(); dset(8'h17, 32'd1); dset(8'h1B, 32'd10);
      run_check("loop");
      check("loop_eax", dut.regs[0], 32'd10);
      check("loop_ebx", dut.regs[3], 32'd55);
      check("loop_ecx", dut.regs[1], 32'd0);
      check("loop_zf", 32'(dut.zf), 32'd1);
      check("loop_opcode", 32'(current_opcode), 32'hF4);
      check("loop_halt_pc", bus_A_ins, 32'h17);

      // same loop followed by a store of ebx
      clear_mem();
      prog_q = '{8'h29, 8'hF6, 8'h29, 8'hC0, 8'h29, 8'hDB, 8'h8B, 8'h56, 8'h17, 8'h01, 8'hD0,
                 8'h01, 8'hC3, 8'h89, 8'hC1, 8'h8B, 8'h56, 8'h1B, 8'h29, 8'hD1, 8'h75, 8'hF0,
                 8'h89, 8'h5E, 8'h30, 8'hF4};
      load_prog(); dset(8'h17, 32'd1); dset(8'h1B, 32'd10);
      run_check("store");
      check("store_pulses", 32'(we_cnt), 32'd1);
      check("store_mem", dword(32'h30), 32'd55);

      // undefined opcode is a 1-byte nop
      clear_mem();
      prog_q = '{8'hB8, 8'hF4};
      load_prog();
      run_check("undef");
      check("undef_pc", bus_A_ins, 32'd2);
      check("undef_eax", dut.regs[0], 32'd0);
      check("undef_zf", 32'(dut.zf), 32'd0);

      // carry out of 0x80000000 + 0x80000000
      clear_mem();
      prog_q = '{8'h8B, 8'h46, 8'h00, 8'h01, 8'hC0, 8'hF4};
      load_prog(); dset(8'h00, 32'h8000_0000);
      run_check("carry");
      check("carry_eax", dut.regs[0], 32'd0);
      check("carry_zf", 32'(dut.zf), 32'd1);
      check("carry_cf", 32'(dut.cf), 32'd1);
      check("carry_sf", 32'(dut.sf), 32'd0);

      for (int t = 0; t < 25; t++) begin
         gen_prog();
         run_check($sformatf("rand%0d", t));
      end

      // reset during the MEM cycle of a store
      clear_mem();
      prog_q = '{8'h8B, 8'h46, 8'h00, 8'h89, 8'h46, 8'h30, 8'hF4};
      load_prog(); dset(8'h00, 32'hA5A5_A5A5);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (!bus_WE && guard < 20);
      check("abort_we_seen", 32'(bus_WE), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("abort_we", 32'(bus_WE), 32'd0);
      check("abort_mem", dword(32'h30), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("abort_restart_addr", bus_A_ins, 32'd0);
      check("abort_restart_re", 32'(bus_RE_ins), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
